// File: rtl/lsb_evt.sv
// Button/switch event capture: turns debounced level changes into sticky
// press/release/long-press/switch-change flags with W1C clearing and a level irq.
`timescale 1ns/1ps
module lsb_evt #(
    parameter int PRESCALE   = 50000,
    parameter int LONG_TICKS = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stb,
    input  logic        we,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack,
    input  logic [3:0]  btn_in,
    input  logic [3:0]  swi_in,
    output logic        irq
);
    localparam logic [15:0] PRE_MAX  = 16'(PRESCALE - 1);
    localparam logic [15:0] LONG_MAX = 16'(LONG_TICKS);

    logic        w_wr;
    logic        w_rd;
    logic        w_clr;
    logic        w_en_wr;
    logic        w_tick;
    logic [15:0] w_clr_bits;
    logic [3:0]  w_press;
    logic [3:0]  w_rel;
    logic [3:0]  w_long;
    logic [3:0]  w_swchg;
    logic        w_unused_bits;

    logic [3:0]  r_btn_q;
    logic [3:0]  r_swi_q;
    logic [15:0] r_pre;
    logic [3:0]  r_ev_press;
    logic [3:0]  r_ev_rel;
    logic [3:0]  r_ev_long;
    logic [3:0]  r_ev_sw;
    logic [3:0]  r_irq_en;
    logic        r_irq;

    assign ack        = stb;
    assign w_wr       = stb & we;
    assign w_rd       = stb & ~we;
    assign w_clr      = w_wr & (data_in[31:30] == 2'b01);
    assign w_en_wr    = w_wr & (data_in[31:30] == 2'b10);
    assign w_clr_bits = w_clr ? data_in[15:0] : 16'h0000;
    assign w_tick     = (r_pre == PRE_MAX);
    assign w_unused_bits = ^data_in[29:16];

    // Edge registers follow the inputs even in reset so a level held
    // through reset is not mistaken for a fresh edge afterwards.
    always_ff @(posedge clk) begin
        r_btn_q <= btn_in;
        r_swi_q <= swi_in;
    end

    always_ff @(posedge clk) begin
        if (rst || w_tick) begin
            r_pre <= 16'h0000;
        end else begin
            r_pre <= r_pre + 16'd1;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_btn
            logic [15:0] r_hold;

            assign w_press[gi] = btn_in[gi] & ~r_btn_q[gi];
            assign w_rel[gi]   = ~btn_in[gi] & r_btn_q[gi];
            assign w_swchg[gi] = swi_in[gi] ^ r_swi_q[gi];
            // Fires only on the step that reaches the threshold; saturation keeps it single-shot.
            assign w_long[gi]  = btn_in[gi] & w_tick & (r_hold == LONG_MAX - 16'd1);

            always_ff @(posedge clk) begin
                if (rst || !btn_in[gi]) begin
                    r_hold <= 16'h0000;
                end else if (w_tick && (r_hold < LONG_MAX)) begin
                    r_hold <= r_hold + 16'd1;
                end
            end
        end
    endgenerate

    // Sticky flags: a new event in the same cycle as its W1C wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ev_press <= 4'h0;
            r_ev_rel   <= 4'h0;
            r_ev_long  <= 4'h0;
            r_ev_sw    <= 4'h0;
            r_irq_en   <= 4'h0;
            r_irq      <= 1'b0;
        end else begin
            r_ev_press <= (r_ev_press & ~w_clr_bits[3:0])   | w_press;
            r_ev_rel   <= (r_ev_rel   & ~w_clr_bits[7:4])   | w_rel;
            r_ev_long  <= (r_ev_long  & ~w_clr_bits[11:8])  | w_long;
            r_ev_sw    <= (r_ev_sw    & ~w_clr_bits[15:12]) | w_swchg;
            if (w_en_wr) begin
                r_irq_en <= data_in[3:0];
            end
            r_irq <= ((|r_ev_press) & r_irq_en[0]) | ((|r_ev_rel) & r_irq_en[1]) |
                     ((|r_ev_long)  & r_irq_en[2]) | ((|r_ev_sw)  & r_irq_en[3]);
        end
    end

    always_comb begin
        data_out = 32'h0000_0000;
        if (w_rd) begin
            data_out = {4'h0, r_irq_en, swi_in, btn_in, r_ev_sw, r_ev_long, r_ev_rel, r_ev_press};
        end
    end

    assign irq = r_irq;
endmodule

// File: tb/tb_lsb_evt.sv
// Bench for lsb_evt: directed scenarios plus randomized traffic against an
// event-level reference model (ticks held per button, sticky flag sets).
`timescale 1ns/1ps
module tb_lsb_evt;
    localparam int PRE = 4;
    localparam int LNG = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb;
    logic        we;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        ack;
    logic [3:0]  btn_in;
    logic [3:0]  swi_in;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [3:0] m_btn_q, m_swi_q, m_press, m_rel, m_long, m_sw, m_en;
    logic       m_irq;
    int         m_cyc;
    int         m_ticks [4];

    lsb_evt #(.PRESCALE(PRE), .LONG_TICKS(LNG)) dut (
        .clk(clk), .rst(rst), .stb(stb), .we(we), .data_in(data_in),
        .data_out(data_out), .ack(ack), .btn_in(btn_in), .swi_in(swi_in), .irq(irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_rd();
        return {4'h0, m_en, swi_in, btn_in, m_sw, m_long, m_rel, m_press};
    endfunction

    task automatic model_step();
        logic [3:0] pr, rl, lg, sw;
        logic [15:0] clr;
        logic tick;
        if (rst) begin
            {m_press, m_rel, m_long, m_sw, m_en} = '0;
            m_irq = 1'b0;
            m_cyc = 0;
            for (int i = 0; i < 4; i++) m_ticks[i] = 0;
        end else begin
            tick = (m_cyc % PRE) == (PRE - 1);
            pr = btn_in & ~m_btn_q;
            rl = ~btn_in & m_btn_q;
            sw = swi_in ^ m_swi_q;
            lg = 4'h0;
            for (int i = 0; i < 4; i++) begin
                if (!btn_in[i]) m_ticks[i] = 0;
                else if (tick && m_ticks[i] < LNG) begin
                    m_ticks[i]++;
                    if (m_ticks[i] == LNG) lg[i] = 1'b1;
                end
            end
            m_irq = ((|m_press) & m_en[0]) | ((|m_rel) & m_en[1]) |
                    ((|m_long) & m_en[2]) | ((|m_sw) & m_en[3]);
            clr = (stb && we && data_in[31:30] == 2'b01) ? data_in[15:0] : 16'h0;
            m_press = (m_press & ~clr[3:0])   | pr;
            m_rel   = (m_rel   & ~clr[7:4])   | rl;
            m_long  = (m_long  & ~clr[11:8])  | lg;
            m_sw    = (m_sw    & ~clr[15:12]) | sw;
            if (stb && we && data_in[31:30] == 2'b10) m_en = data_in[3:0];
            m_cyc++;
        end
        m_btn_q = btn_in;
        m_swi_q = swi_in;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bus(input logic s, input logic w, input logic [31:0] d);
        stb = s; we = w; data_in = d;
        if (s) $display("tx t=%0t %s data_in=%08h btn=%b swi=%b", $time, w ? "WR" : "RD", d, btn_in, swi_in);
    endtask

    task automatic test_reset();
        rst = 1'b1; btn_in = 4'b0001; swi_in = 4'b0000;
        bus(1'b0, 1'b0, 32'h0);
        repeat (3) cyc();
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b want=0", irq); end
        rst = 1'b0;
        bus(1'b1, 1'b0, 32'h0); #1;
        checks++;
        if (data_out !== 32'h0001_0000) begin failures++; $display("FAIL reset_read got=%08h want=00010000", data_out); end
        checks++;
        if (ack !== 1'b1) begin failures++; $display("FAIL reset_ack got=%b want=1", ack); end
        cyc();
        bus(1'b0, 1'b0, 32'h0);
        repeat (11) cyc();
        bus(1'b1, 1'b0, 32'h0); #1;
        checks++;
        if (data_out[8] !== 1'b1) begin failures++; $display("FAIL reset_long got=%b want=1", data_out[8]); end
        checks++;
        if (data_out !== exp_rd()) begin failures++; $display("FAIL reset_long_word got=%08h want=%08h", data_out, exp_rd()); end
        cyc();
        btn_in = 4'b0000;
        bus(1'b0, 1'b0, 32'h0); cyc();
        bus(1'b1, 1'b1, 32'h4000_FFFF); cyc();
    endtask

    task automatic test_press_release();
        btn_in = 4'b0100;
        bus(1'b0, 1'b0, 32'h0); cyc();
        bus(1'b1, 1'b0, 32'h0); #1;
        checks++;
        if (data_out[3:0] !== 4'b0100 || data_out[19:16] !== 4'b0100) begin
            failures++; $display("FAIL press_flag got=%08h want=xxx4xxx4", data_out);
        end
        cyc();
        btn_in = 4'b0000;
        bus(1'b0, 1'b0, 32'h0); cyc();
        bus(1'b1, 1'b0, 32'h0); #1;
        checks++;
        if (data_out[7:4] !== 4'b0100) begin failures++; $display("FAIL release_flag got=%b want=0100", data_out[7:4]); end
        cyc();
        bus(1'b1, 1'b1, 32'h4000_0044); cyc();
        bus(1'b1, 1'b0, 32'h0); #1;
        checks++;
        if (data_out[7:0] !== 8'h00) begin failures++; $display("FAIL w1c_clear got=%02h want=00", data_out[7:0]); end
        checks++;
        if (data_out !== exp_rd()) begin failures++; $display("FAIL w1c_word got=%08h want=%08h", data_out, exp_rd()); end
        cyc();
    endtask

    task automatic test_long();
        btn_in = 4'b0010;
        bus(1'b0, 1'b0, 32'h0);
        repeat (8) cyc();
        btn_in = 4'b0000; cyc();
        bus(1'b1, 1'b0, 32'h0); #1;
        checks++;
        if (data_out[9] !== 1'b0) begin failures++; $display("FAIL short_hold_long got=%b want=0", data_out[9]); end
        cyc();
        btn_in = 4'b0010;
        bus(1'b0, 1'b0, 32'h0);
        repeat (20) cyc();
        bus(1'b1, 1'b0, 32'h0); #1;
        checks++;
        if (data_out[9] !== 1'b1) begin failures++; $display("FAIL long_hold got=%b want=1", data_out[9]); end
        checks++;
        if (data_out !== exp_rd()) begin failures++; $display("FAIL long_word got=%08h want=%08h", data_out, exp_rd()); end
        cyc();
        bus(1'b1, 1'b1, 32'h4000_0200); cyc();
        bus(1'b0, 1'b0, 32'h0);
        repeat (8) cyc();
        bus(1'b1, 1'b0, 32'h0); #1;
        checks++;
        if (data_out[9] !== 1'b0) begin failures++; $display("FAIL long_once got=%b want=0", data_out[9]); end
        cyc();
        btn_in = 4'b0000;
        bus(1'b0, 1'b0, 32'h0); cyc();
    endtask

    task automatic test_irq_sw();
        bus(1'b1, 1'b1, 32'h8000_0008); cyc();
        swi_in = swi_in ^ 4'b0100;
        bus(1'b0, 1'b0, 32'h0); cyc();
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_early got=%b want=0", irq); end
        bus(1'b1, 1'b0, 32'h0); #1;
        checks++;
        if (data_out[14] !== 1'b1) begin failures++; $display("FAIL swchg_flag got=%b want=1", data_out[14]); end
        cyc();
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL irq_set got=%b want=1", irq); end
        bus(1'b1, 1'b1, 32'h4000_4000); cyc();
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL irq_hold got=%b want=1", irq); end
        bus(1'b0, 1'b0, 32'h0); cyc();
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_drop got=%b want=0", irq); end
    endtask

    task automatic test_set_wins();
        btn_in = 4'b0001;
        bus(1'b1, 1'b1, 32'h4000_0001); cyc();
        bus(1'b1, 1'b0, 32'h0); #1;
        checks++;
        if (data_out[0] !== 1'b1) begin failures++; $display("FAIL set_wins got=%b want=1", data_out[0]); end
        cyc();
    endtask

    task automatic test_ctrl_ignore();
        logic [31:0] snap;
        bus(1'b0, 1'b0, 32'h0); cyc();
        snap = exp_rd();
        bus(1'b1, 1'b1, 32'hC000_FFFF); cyc();
        bus(1'b1, 1'b1, 32'h0000_FFFF); cyc();
        bus(1'b1, 1'b0, 32'h0); #1;
        checks++;
        if (data_out !== snap) begin failures++; $display("FAIL ctrl_ignore got=%08h want=%08h", data_out, snap); end
        checks++;
        if (data_out[27:24] !== 4'b1000) begin failures++; $display("FAIL irq_en_kept got=%b want=1000", data_out[27:24]); end
        cyc();
        bus(1'b0, 1'b0, 32'h0); #1;
        checks++;
        if (data_out !== 32'h0 || ack !== 1'b0) begin
            failures++; $display("FAIL idle_bus got=%08h/%b want=00000000/0", data_out, ack);
        end
        cyc();
    endtask

    task automatic test_random();
        int op;
        for (int n = 0; n < 300; n++) begin
            rst = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 5) == 0) btn_in = btn_in ^ (4'b0001 << $urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) swi_in = swi_in ^ (4'b0001 << $urandom_range(0, 3));
            op = $urandom_range(0, 2);
            if (op == 2) bus(1'b1, 1'b1, {2'($urandom_range(0, 3)), 14'h0, 16'($urandom)});
            else bus(op == 1, 1'b0, 32'h0);
            #1;
            checks++;
            if (data_out !== (op == 1 ? exp_rd() : 32'h0) || ack !== (op != 0)) begin
                failures++;
                $display("FAIL rand_bus n=%0d got=%08h/%b want=%08h/%b", n, data_out, ack,
                         op == 1 ? exp_rd() : 32'h0, op != 0);
            end
            cyc();
            checks++;
            if (irq !== m_irq) begin failures++; $display("FAIL rand_irq n=%0d got=%b want=%b", n, irq, m_irq); end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stb = 1'b0; we = 1'b0; data_in = 32'h0;
        btn_in = 4'b0001; swi_in = 4'b0000;
        @(negedge clk);
        test_reset();
        test_press_release();
        test_long();
        test_irq_sw();
        test_set_wins();
        test_ctrl_ignore();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
